// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, sequencer states and the one rule
// deciding which opcodes produce a result on the bus.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_NOP      = 3'd0,
      ALU_WRITE_R0 = 3'd1,
      ALU_WRITE_R1 = 3'd2,
      ALU_ADD      = 3'd3,
      ALU_SUB      = 3'd4,
      ALU_AND      = 3'd5,
      ALU_OR       = 3'd6,
      ALU_XOR      = 3'd7
   } alu_op_t;

   typedef enum logic [2:0] {
      SEQ_IDLE   = 3'd0,
      SEQ_LOAD_A = 3'd1,
      SEQ_LOAD_B = 3'd2,
      SEQ_EXEC   = 3'd3,
      SEQ_RESP   = 3'd4
   } alu_seq_state_t;

   // Arithmetic opcodes are exactly those for which the ALU drives the bus.
   function automatic logic alu_op_is_arith(input alu_op_t i_op);
      return !(i_op inside {ALU_NOP, ALU_WRITE_R0, ALU_WRITE_R1});
   endfunction

endpackage

// File: rtl/alu.sv
// Bus-attached ALU: latches R0/R1 from the bus on write opcodes and drives the
// result combinationally onto the bus while an arithmetic opcode is presented.
module alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  alu_op_t          op,
   inout  wire  [WIDTH-1:0] bus
);

   logic [WIDTH-1:0] r_r0;
   logic [WIDTH-1:0] r_r1;
   logic [WIDTH-1:0] w_result;
   logic             w_drive;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_r0 <= '0;
         r_r1 <= '0;
      end else begin
         if (op == ALU_WRITE_R0) r_r0 <= bus;
         if (op == ALU_WRITE_R1) r_r1 <= bus;
      end
   end

   always_comb begin
      w_result = '0;
      unique case (op)
         ALU_ADD: w_result = r_r0 + r_r1;
         ALU_SUB: w_result = r_r0 - r_r1;
         ALU_AND: w_result = r_r0 & r_r1;
         ALU_OR:  w_result = r_r0 | r_r1;
         ALU_XOR: w_result = r_r0 ^ r_r1;
         default: w_result = '0;
      endcase
   end

   assign w_drive = alu_op_is_arith(op);

   tri_buf #(.WIDTH(WIDTH)) u_tri_buf (
      .i_en   (w_drive),
      .i_data (w_result),
      .io_bus (bus)
   );

endmodule

// File: rtl/tri_buf.sv
// Parameterised tri-state driver onto a shared bus; releases to z when disabled.
module tri_buf #(
   parameter int WIDTH = 8
) (
   input  logic             i_en,
   input  logic [WIDTH-1:0] i_data,
   inout  wire  [WIDTH-1:0] io_bus
);

   assign io_bus = i_en ? i_data : {WIDTH{1'bz}};

endmodule

// File: rtl/alu_sequencer.sv
// Request sequencer in front of the ALU: loads R0, loads R1, executes, then
// holds the captured bus result until the consumer takes it.
module alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  alu_op_t          req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_error,
   output alu_op_t          op,
   inout  wire  [WIDTH-1:0] bus
);

   alu_seq_state_t   r_state;
   alu_seq_state_t   w_state_nxt;
   alu_op_t          r_op_lat;
   alu_op_t          r_op;
   alu_op_t          w_op_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_resp_data;
   logic [WIDTH-1:0] w_drv_data;
   logic             r_resp_error;
   logic             r_drv_en;
   logic             w_drv_en_nxt;
   logic             w_accept;

   assign w_accept = req_valid && (r_state == SEQ_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= SEQ_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         SEQ_IDLE: begin
            if (w_accept) w_state_nxt = alu_op_is_arith(req_op) ? SEQ_LOAD_A : SEQ_RESP;
         end
         SEQ_LOAD_A: w_state_nxt = SEQ_LOAD_B;
         SEQ_LOAD_B: w_state_nxt = SEQ_EXEC;
         SEQ_EXEC:   w_state_nxt = SEQ_RESP;
         SEQ_RESP: begin
            if (resp_ready) w_state_nxt = SEQ_IDLE;
         end
         default:    w_state_nxt = SEQ_IDLE;
      endcase
   end

   // Opcode and driver enable are decoded from the upcoming state and
   // registered together, so the bus is released on the same edge the ALU's
   // opcode switches to an arithmetic one.
   always_comb begin
      w_op_nxt     = ALU_NOP;
      w_drv_en_nxt = 1'b0;
      unique case (w_state_nxt)
         SEQ_LOAD_A: begin
            w_op_nxt     = ALU_WRITE_R0;
            w_drv_en_nxt = 1'b1;
         end
         SEQ_LOAD_B: begin
            w_op_nxt     = ALU_WRITE_R1;
            w_drv_en_nxt = 1'b1;
         end
         SEQ_EXEC: w_op_nxt = r_op_lat;
         default: begin
            w_op_nxt     = ALU_NOP;
            w_drv_en_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_op     <= ALU_NOP;
         r_drv_en <= 1'b0;
      end else begin
         r_op     <= w_op_nxt;
         r_drv_en <= w_drv_en_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_op_lat     <= ALU_NOP;
         r_a          <= '0;
         r_b          <= '0;
         r_resp_data  <= '0;
         r_resp_error <= 1'b0;
      end else if (w_accept) begin
         r_op_lat     <= req_op;
         r_a          <= req_a;
         r_b          <= req_b;
         r_resp_error <= !alu_op_is_arith(req_op);
         if (!alu_op_is_arith(req_op)) r_resp_data <= '0;
      end else if (r_state == SEQ_EXEC) begin
         r_resp_data <= bus;
      end
   end

   assign w_drv_data = (r_op == ALU_WRITE_R0) ? r_a : r_b;

   tri_buf #(.WIDTH(WIDTH)) u_tri_buf (
      .i_en   (r_drv_en),
      .i_data (w_drv_data),
      .io_bus (bus)
   );

   assign req_ready  = (r_state == SEQ_IDLE);
   assign resp_valid = (r_state == SEQ_RESP);
   assign resp_data  = r_resp_data;
   assign resp_error = r_resp_error;
   assign op         = r_op;

endmodule

// File: tb/tb_alu_sequencer.sv
// Pairs alu_sequencer with the bus-attached alu and checks opcodes, bus values
// and responses against an expected-result queue.
module tb_alu_sequencer;
   import alu_pkg::*;

   localparam int W = 8;
   localparam logic [W-1:0] BUS_IDLE = {W{1'b1}};

   logic         clock = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_ready;
   alu_op_t      req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         resp_valid;
   logic         resp_ready;
   logic [W-1:0] resp_data;
   logic         resp_error;
   alu_op_t      op;
   tri1  [W-1:0] bus;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [W:0] exp_q[$];

   alu_sequencer #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_data  (resp_data),
      .resp_error (resp_error),
      .op         (op),
      .bus        (bus)
   );

   alu #(.WIDTH(W)) u_alu (
      .clock (clock),
      .reset (reset),
      .op    (op),
      .bus   (bus)
   );

   // clock / reset
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // {error, data} the ALU contract promises for a request
   function automatic logic [W:0] model(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b);
      case (o)
         ALU_ADD: return {1'b0, a + b};
         ALU_SUB: return {1'b0, a - b};
         ALU_AND: return {1'b0, a & b};
         ALU_OR:  return {1'b0, a | b};
         ALU_XOR: return {1'b0, a ^ b};
         default: return {1'b1, {W{1'b0}}};
      endcase
   endfunction

   // driver tasks
   task automatic send(input alu_op_t o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      int n = 0;
      req_op    = o;
      req_a     = a;
      req_b     = b;
      req_valid = 1'b1;
      while (!req_ready && n < 50) begin
         step();
         n++;
      end
      if (!req_ready) check("accept_timeout", 32'd0, 32'd1);
      step();
      req_valid = 1'b0;
      if (push) exp_q.push_back(model(o, a, b));
   endtask

   task automatic wait_resp();
      int n = 0;
      while (!resp_valid && n < 20) begin
         step();
         n++;
      end
      if (!resp_valid) check("resp_timeout", 32'd0, 32'd1);
   endtask

   // scoreboard: compare on the cycle the response handshake completes
   always @(negedge clock) begin
      if (!reset) check("bus_known", {31'd0, $isunknown(bus)}, 32'd0);
      if (!reset && resp_valid && resp_ready) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_resp", 32'd1, 32'd0);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            check("sb_resp_data", {24'd0, resp_data}, {24'd0, e[W-1:0]});
            check("sb_resp_error", {31'd0, resp_error}, {31'd0, e[W]});
         end
      end
   end

   initial begin
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = ALU_NOP;
      req_a      = '0;
      req_b      = '0;
      resp_ready = 1'b1;
      step();
      step();
      check("rst_req_ready", {31'd0, req_ready}, 32'd1);
      check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst_resp_data", {24'd0, resp_data}, 32'd0);
      check("rst_resp_error", {31'd0, resp_error}, 32'd0);
      check("rst_op", {29'd0, op}, {29'd0, ALU_NOP});
      check("rst_bus", {24'd0, bus}, {24'd0, BUS_IDLE});
      reset = 1'b0;
      step();

      // add: opcode and bus sequence cycle by cycle
      send(ALU_ADD, 8'd1, 8'd5, 1'b1);
      check("add_op0", {29'd0, op}, {29'd0, ALU_WRITE_R0});
      check("add_bus0", {24'd0, bus}, 32'd1);
      check("add_ready0", {31'd0, req_ready}, 32'd0);
      step();
      check("add_op1", {29'd0, op}, {29'd0, ALU_WRITE_R1});
      check("add_bus1", {24'd0, bus}, 32'd5);
      step();
      check("add_op2", {29'd0, op}, {29'd0, ALU_ADD});
      check("add_bus2", {24'd0, bus}, 32'd6);
      check("add_valid2", {31'd0, resp_valid}, 32'd0);
      step();
      check("add_op3", {29'd0, op}, {29'd0, ALU_NOP});
      check("add_valid3", {31'd0, resp_valid}, 32'd1);
      check("add_data", {24'd0, resp_data}, 32'd6);
      check("add_error", {31'd0, resp_error}, 32'd0);
      check("add_bus3", {24'd0, bus}, {24'd0, BUS_IDLE});
      step();
      check("add_idle", {31'd0, req_ready}, 32'd1);

      // wrap
      send(ALU_ADD, 8'd200, 8'd100, 1'b1);
      wait_resp();
      check("wrap_data", {24'd0, resp_data}, 32'd44);
      step();

      // backpressure
      resp_ready = 1'b0;
      send(ALU_ADD, 8'd3, 8'd4, 1'b1);
      step();
      step();
      step();
      req_op    = ALU_ADD;
      req_a     = 8'd9;
      req_b     = 8'd9;
      req_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         check("bp_valid", {31'd0, resp_valid}, 32'd1);
         check("bp_data", {24'd0, resp_data}, 32'd7);
         check("bp_ready", {31'd0, req_ready}, 32'd0);
         check("bp_op", {29'd0, op}, {29'd0, ALU_NOP});
         step();
      end
      req_valid  = 1'b0;
      resp_ready = 1'b1;
      step();
      check("bp_release_valid", {31'd0, resp_valid}, 32'd0);
      check("bp_release_ready", {31'd0, req_ready}, 32'd1);
      send(ALU_SUB, 8'd10, 8'd3, 1'b1);
      check("bp_next_accept", {29'd0, op}, {29'd0, ALU_WRITE_R0});
      wait_resp();
      check("sub_data", {24'd0, resp_data}, 32'd7);
      step();

      // illegal opcode never touches the bus
      check("ill_bus_pre", {24'd0, bus}, {24'd0, BUS_IDLE});
      send(ALU_WRITE_R0, 8'd9, 8'd9, 1'b1);
      check("ill_valid", {31'd0, resp_valid}, 32'd1);
      check("ill_error", {31'd0, resp_error}, 32'd1);
      check("ill_data", {24'd0, resp_data}, 32'd0);
      check("ill_op", {29'd0, op}, {29'd0, ALU_NOP});
      check("ill_bus", {24'd0, bus}, {24'd0, BUS_IDLE});
      step();
      check("ill_bus_post", {24'd0, bus}, {24'd0, BUS_IDLE});

      // asynchronous reset while in LOAD_B
      send(ALU_XOR, 8'h5a, 8'h33, 1'b0);
      step();
      check("rb_op", {29'd0, op}, {29'd0, ALU_WRITE_R1});
      check("rb_bus", {24'd0, bus}, 32'h33);
      #2 reset = 1'b1;
      #1;
      check("rb_async_op", {29'd0, op}, {29'd0, ALU_NOP});
      check("rb_async_bus", {24'd0, bus}, {24'd0, BUS_IDLE});
      check("rb_async_ready", {31'd0, req_ready}, 32'd1);
      check("rb_async_valid", {31'd0, resp_valid}, 32'd0);
      check("rb_async_data", {24'd0, resp_data}, 32'd0);
      check("rb_async_error", {31'd0, resp_error}, 32'd0);
      step();
      reset = 1'b0;
      send(ALU_ADD, 8'd2, 8'd2, 1'b1);
      wait_resp();
      check("rb_after_data", {24'd0, resp_data}, 32'd4);
      step();

      // back-to-back random adds
      for (int i = 0; i < 10; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         send(ALU_ADD, a, b, 1'b1);
      end
      for (int n = 0; n < 40 && exp_q.size() != 0; n++) step();
      step();

      // final report
      check("sb_empty", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Control stage directly upstream of the ALU. Accepts one arithmetic request (opcode plus two operands) per valid/ready handshake and drives the ALU's `op` input and the shared 8-bit data bus, through its own tri-state driver, over three bus cycles: load R0, load R1, execute. It captures the ALU result from the bus and presents it on a response handshake. It is the only agent that issues ALU opcodes.

## Interface
Parameters:
- `WIDTH`, 8, data/bus width.

Ports:
- `clock`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept a request.
- `req_op`  in  `alu_op_t`  operation to execute.
- `req_a`  in  WIDTH  operand for R0.
- `req_b`  in  WIDTH  operand for R1.
- `resp_valid`  out  1  result held.
- `resp_ready`  in  1  consumer takes the result.
- `resp_data`  out  WIDTH  captured ALU result.
- `resp_error`  out  1  request carried a non-arithmetic opcode.
- `op`  out  `alu_op_t`  ALU opcode.
- `bus`  inout  WIDTH  shared data bus, driven through an internal `tri_buf`.

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, RESP.
- IDLE:
  - `req_ready`=1, `op`=ALU_NOP, bus released (z).
  - `req_valid`&&`req_ready` at a rising edge latches `req_op`/`req_a`/`req_b`.
  - Legal opcode: go to LOAD_A.
  - ALU_NOP, ALU_WRITE_R0 or ALU_WRITE_R1: go straight to RESP with `resp_error`=1 and `resp_data`=0. The bus is never touched.
- LOAD_A: `op`=ALU_WRITE_R0, bus driven with latched A. Next state LOAD_B.
- LOAD_B: `op`=ALU_WRITE_R1, bus driven with latched B. Next state EXEC.
- EXEC:
  - `op`=latched opcode, sequencer's driver released so the ALU drives the bus.
  - At the closing edge, capture `bus` into `resp_data`, then go to RESP.
- RESP:
  - `resp_valid`=1, `op`=ALU_NOP, bus released. `resp_data` and `resp_error` are held stable.
  - `resp_valid`&&`resp_ready` at an edge returns to IDLE.
- Arithmetic is the ALU's: the result is modulo 2^WIDTH and is captured as-is, with no carry output.
- Reset values: state IDLE, `req_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_error`=0, `op`=ALU_NOP, bus driver disabled.

## Timing
- All outputs are registered or decoded from state only. No combinational path from `req_*` or `resp_ready` to any output.
- Latency for a legal op, counting the handshake edge as edge 0: LOAD_A after edge 0, LOAD_B after edge 1, EXEC after edge 2, `resp_valid`=1 after edge 3. An illegal op gives `resp_valid`=1 after edge 0.
- The bus driver is enabled only in LOAD_A and LOAD_B, and the driver-enable flop changes on the same edge as `op`. EXEC never has the sequencer driving the bus, so there is no contention with the ALU.
- No back-to-back overlap: `req_ready`=0 from LOAD_A through RESP. The earliest next accept is the edge after the RESP handshake. Throughput is 1 op per 5 cycles with `resp_ready` tied high.
- `resp_ready` held low keeps RESP indefinitely. `req_valid` is ignored outside IDLE.
- Asserting `reset` in any state immediately forces the reset values, without waiting for an edge. The bus goes z and the in-flight request is dropped with no response. After `reset` deasserts, the first edge may accept a new request.

## Structure
- Shared package (`alu_pkg`, already holds `alu_op_t`) gains:
  - `alu_seq_state_t`, an enum of the five states.
  - An `alu_op_is_arith()` function, the single legality rule shared with the ALU.
- Sub-module: instantiate the existing `tri_buf` (WIDTH parameter) for the bus drive. Everything else is flat in `alu_sequencer`.

## Test plan
- Bench pairs `alu_sequencer` with a real `alu` on a shared bus and checks `op` each cycle.
- Add: req (ALU_ADD, 1, 5), `resp_ready`=1.
  - `op` sequence: WRITE_R0 → WRITE_R1 → ADD → NOP.
  - Bus carries 1, then 5, then 6.
  - `resp_data`=6 and `resp_error`=0 on the 4th edge after accept.
- Wrap: (ALU_ADD, 200, 100) → `resp_data`=44.
- Backpressure: (ALU_ADD, 3, 4) with `resp_ready`=0 for 6 cycles.
  - `resp_valid` and `resp_data`=7 hold stable; `req_ready`=0 throughout.
  - A second `req_valid` in that window is not accepted.
  - Release `resp_ready`: back to IDLE in one edge; the next request is accepted on the following edge.
- Illegal op: (ALU_WRITE_R0, 9, 9) → `resp_valid` one edge after accept, `resp_error`=1, `resp_data`=0, bus stays z throughout.
- Reset in LOAD_B: assert `reset` mid-cycle.
  - Outputs reach their reset values before the next edge, bus z.
  - After release, (ALU_ADD, 2, 2) yields 4.
- Bus hygiene: over a back-to-back stream of 10 random ADDs, the bus is never X, and `resp_data` equals the sum mod 256 each time.
